hms_countdown_timer: RTL and testbench
======================================

HMS_COUNTDOWN_TIMER -- requirements
Module: hms_countdown_timer

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- SEC_MAX, 59, terminal seconds value.
- MIN_MAX, 59, terminal minutes value.
- HRS_MAX, 23, terminal hours value.
- O, 6, seconds/minutes field width.
- P, 5, hours field width.
REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk, in, 1, the single clock; all state updates on the rising edge.
- rst, in, 1, asynchronous, active-high reset.
- tick, in, 1, one-second enable strobe.
- load, in, 1, load preset.
- load_hrs, in, P, preset hours.
- load_min, in, O, preset minutes.
- load_sec, in, O, preset seconds.
- start, in, 1, start or resume.
- pause, in, 1, suspend.
- hrs, out, P, remaining hours.
- min, out, O, remaining minutes.
- sec, out, O, remaining seconds.
- running, out, 1, high in RUN.
- done, out, 1, one-cycle expiry pulse.

Function
REQ-003 The FSM SHALL have the states IDLE, RUN and HOLD; running SHALL be 1 only in RUN.
REQ-004 load SHALL act in any state: count <= preset, shadow <= preset, next state IDLE, done = 0. load SHALL have priority over start, pause and tick in the same cycle.
REQ-005 Preset fields above their MAX SHALL saturate to MAX (e.g. load_sec = 63 -> sec = SEC_MAX).
REQ-006 start in IDLE with a nonzero count SHALL go to RUN on the next edge; start with count 0:00:00 SHALL be ignored (no done pulse).
REQ-007 pause in RUN SHALL go to HOLD; start in HOLD SHALL go to RUN; pause outside RUN SHALL be ignored; start and pause together in RUN SHALL resolve to pause.
REQ-008 tick SHALL decrement only in RUN and SHALL be ignored in IDLE and HOLD; a tick in the same cycle as pause SHALL be ignored.
REQ-009 The decrement SHALL work as follows:
- sec > 0: sec - 1.
- Otherwise, min > 0: min - 1, sec = SEC_MAX.
- Otherwise, hrs > 0: hrs - 1, min = MIN_MAX, sec = SEC_MAX.
REQ-010 At the edge where a RUN tick makes the count 0:00:00, done SHALL be 1 for exactly the following cycle and the state SHALL go to IDLE (latency 0 from the count edge).
REQ-011 The count SHALL never wrap below zero, and SHALL never exceed the MAX values.
REQ-012 Outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-013 rst SHALL asynchronously force: hrs = 0, min = 0, sec = 0, shadow = 0, state IDLE, running = 0, done = 0.
REQ-014 rst asserted mid-RUN SHALL abort the countdown; after release the block SHALL require load and start before counting.

Configuration
REQ-015 With HMS_CDT_AUTO_RELOAD_EN defined, expiry SHALL assert done for one cycle, reload the count from shadow at the same edge, and remain in RUN. If shadow is 0:00:00, the block SHALL go to IDLE instead.
REQ-016 Without HMS_CDT_AUTO_RELOAD_EN, expiry SHALL behave per REQ-010, and the shadow register SHALL NOT be synthesised.

Structure
REQ-017 Package hms_pkg SHALL hold the state enum (IDLE, RUN, HOLD) and the default MAX and width constants shared with the up-counting hours/minutes/seconds counter.
REQ-018 Sub-module hms_down_field SHALL implement one saturating down field:
- Inputs: value, borrow-in, MAX.
- Outputs: next value, borrow-out.
- Instantiated three times (sec, min, hrs).

Verification
REQ-019 The bench SHALL cover the following directed scenarios, one per line as stimulus -> required response.
- Load 0:01:00, start, then 1 tick -> 0:00:59; 59 more ticks -> 0:00:00, done for 1 cycle, running = 0.
- Load 1:00:00, start, then 1 tick -> 0:59:59; then pause, 5 ticks -> count unchanged at 0:59:59; start, 1 tick -> 0:59:58.
- Load 0:00:00, start -> stays IDLE, done never asserts; load_sec = 63 -> sec = 59.
- In RUN at 0:00:05, assert load 0:00:02 together with tick -> count 0:00:02, IDLE, no decrement.
- rst asserted mid-RUN at 2:10:30 -> all outputs 0 immediately, before the next clk edge.
- With HMS_CDT_AUTO_RELOAD_EN, load 0:00:02, start, then 2 ticks -> done pulse, count 0:00:02, running stays 1.

Source files
------------

// File: rtl/hms_pkg.sv
// ============================================================================
// Module      : hms_pkg
// Description : Shared state encoding and default hours/minutes/seconds limits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hms_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int c_SEC_MAX = 59;
    localparam int c_MIN_MAX = 59;
    localparam int c_HRS_MAX = 23;
    localparam int c_FIELD_W = 6;
    localparam int c_HRS_W   = 5;

endpackage

`default_nettype wire

// File: rtl/hms_countdown_timer_if.sv
// ============================================================================
// Module      : hms_countdown_timer_if
// Description : Control, preset and status bundle for the countdown timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hms_countdown_timer_if
    import hms_pkg::*;
#(
    parameter int O = c_FIELD_W,
    parameter int P = c_HRS_W
);
    logic         tick;
    logic         load;
    logic [P-1:0] load_hrs;
    logic [O-1:0] load_min;
    logic [O-1:0] load_sec;
    logic         start;
    logic         pause;
    logic [P-1:0] hrs;
    logic [O-1:0] min;
    logic [O-1:0] sec;
    logic         running;
    logic         done;

    modport master (
        output tick, load, load_hrs, load_min, load_sec, start, pause,
        input  hrs, min, sec, running, done
    );

    modport slave (
        input  tick, load, load_hrs, load_min, load_sec, start, pause,
        output hrs, min, sec, running, done
    );
endinterface

`default_nettype wire

// File: rtl/hms_down_field.sv
// ============================================================================
// Module      : hms_down_field
// Description : One saturating down-counting field; wraps to max_val on borrow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hms_down_field #(
    parameter int W = 6
) (
    input  wire logic [W-1:0] value,
    input  wire logic         borrow_in,
    input  wire logic [W-1:0] max_val,
    output logic      [W-1:0] next_value,
    output logic              borrow_out
);

    always_comb begin
        next_value = value;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (value != '0) begin
                next_value = value - 1'b1;
            end else begin
                next_value = max_val;
                borrow_out = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/hms_countdown_timer.sv
// ============================================================================
// Module      : hms_countdown_timer
// Description : Hours/minutes/seconds countdown with load, start and pause.
//               HMS_CDT_AUTO_RELOAD_EN: reload from the preset shadow on expiry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hms_countdown_timer
    import hms_pkg::*;
#(
    parameter int SEC_MAX = c_SEC_MAX,
    parameter int MIN_MAX = c_MIN_MAX,
    parameter int HRS_MAX = c_HRS_MAX,
    parameter int O       = c_FIELD_W,
    parameter int P       = c_HRS_W
) (
    input wire logic               clk,
    input wire logic               rst,
    hms_countdown_timer_if.slave   bus
);

    localparam logic [O-1:0] c_SEC = O'(SEC_MAX);
    localparam logic [O-1:0] c_MIN = O'(MIN_MAX);
    localparam logic [P-1:0] c_HRS = P'(HRS_MAX);

    state_t       r_state, w_state_nxt;
    logic [P-1:0] r_hrs, w_hrs_nxt, w_hrs_dec, w_ld_hrs;
    logic [O-1:0] r_min, w_min_nxt, w_min_dec, w_ld_min;
    logic [O-1:0] r_sec, w_sec_nxt, w_sec_dec, w_ld_sec;
    logic         r_done, w_done_nxt;
    logic         w_zero, w_dec, w_dec_ok, w_expire;
    logic         w_b_sec, w_b_min, w_b_hrs;

    assign w_ld_hrs = (bus.load_hrs > c_HRS) ? c_HRS : bus.load_hrs;
    assign w_ld_min = (bus.load_min > c_MIN) ? c_MIN : bus.load_min;
    assign w_ld_sec = (bus.load_sec > c_SEC) ? c_SEC : bus.load_sec;

    assign w_zero = (r_hrs == '0) && (r_min == '0) && (r_sec == '0);
    assign w_dec  = (r_state == RUN) && bus.tick && !bus.pause && !bus.load;

    hms_down_field #(.W(O)) u_sec (
        .value(r_sec), .borrow_in(w_dec), .max_val(c_SEC),
        .next_value(w_sec_dec), .borrow_out(w_b_sec)
    );
    hms_down_field #(.W(O)) u_min (
        .value(r_min), .borrow_in(w_b_sec), .max_val(c_MIN),
        .next_value(w_min_dec), .borrow_out(w_b_min)
    );
    hms_down_field #(.W(P)) u_hrs (
        .value(r_hrs), .borrow_in(w_b_min), .max_val(c_HRS),
        .next_value(w_hrs_dec), .borrow_out(w_b_hrs)
    );

    // A borrow out of the hours field means 0:00:00 would wrap; block it.
    assign w_dec_ok = w_dec && !w_b_hrs;
    assign w_expire = w_dec_ok && (w_hrs_dec == '0) && (w_min_dec == '0) && (w_sec_dec == '0);

`ifdef HMS_CDT_AUTO_RELOAD_EN
    logic [P-1:0] r_sh_hrs;
    logic [O-1:0] r_sh_min;
    logic [O-1:0] r_sh_sec;
    logic         w_sh_zero;

    assign w_sh_zero = (r_sh_hrs == '0) && (r_sh_min == '0) && (r_sh_sec == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_hrs <= '0;
            r_sh_min <= '0;
            r_sh_sec <= '0;
        end else if (bus.load) begin
            r_sh_hrs <= w_ld_hrs;
            r_sh_min <= w_ld_min;
            r_sh_sec <= w_ld_sec;
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_hrs_nxt   = r_hrs;
        w_min_nxt   = r_min;
        w_sec_nxt   = r_sec;
        w_done_nxt  = 1'b0;
        if (bus.load) begin
            w_state_nxt = IDLE;
            w_hrs_nxt   = w_ld_hrs;
            w_min_nxt   = w_ld_min;
            w_sec_nxt   = w_ld_sec;
        end else begin
            case (r_state)
                IDLE:    if (bus.start && !w_zero) w_state_nxt = RUN;
                RUN:     if (bus.pause)            w_state_nxt = HOLD;
                HOLD:    if (bus.start)            w_state_nxt = RUN;
                default:                           w_state_nxt = IDLE;
            endcase
            if (w_dec_ok) begin
                w_hrs_nxt = w_hrs_dec;
                w_min_nxt = w_min_dec;
                w_sec_nxt = w_sec_dec;
            end
            if (w_expire) begin
                w_done_nxt = 1'b1;
`ifdef HMS_CDT_AUTO_RELOAD_EN
                if (w_sh_zero) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_hrs_nxt = r_sh_hrs;
                    w_min_nxt = r_sh_min;
                    w_sec_nxt = r_sh_sec;
                end
`else
                w_state_nxt = IDLE;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_hrs   <= '0;
            r_min   <= '0;
            r_sec   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hrs   <= w_hrs_nxt;
            r_min   <= w_min_nxt;
            r_sec   <= w_sec_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign bus.hrs     = r_hrs;
    assign bus.min     = r_min;
    assign bus.sec     = r_sec;
    assign bus.running = (r_state == RUN);
    assign bus.done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_hms_countdown_timer.sv
// ============================================================================
// Module      : tb_hms_countdown_timer
// Description : Directed scoreboard bench for hms_countdown_timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hms_countdown_timer;

    typedef struct packed {
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic       r;
        logic       d;
    } snap_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    snap_t sb_q[$];
    string tag_q[$];

    hms_countdown_timer_if #(.O(6), .P(5)) bus ();

    hms_countdown_timer #(
        .SEC_MAX(59), .MIN_MAX(59), .HRS_MAX(23), .O(6), .P(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input bit tk = 0, input bit ld = 0, input bit st = 0,
                       input bit ps = 0, input int lh = 0, input int lm = 0,
                       input int ls = 0);
        bus.tick     = tk;
        bus.load     = ld;
        bus.start    = st;
        bus.pause    = ps;
        bus.load_hrs = 5'(lh);
        bus.load_min = 6'(lm);
        bus.load_sec = 6'(ls);
        @(posedge clk);
        #1;
        bus.tick  = 1'b0;
        bus.load  = 1'b0;
        bus.start = 1'b0;
        bus.pause = 1'b0;
    endtask

    task automatic expect_out(input string tag, input int h, input int m,
                              input int s, input bit r, input bit d);
        snap_t e;
        e.h = 5'(h);
        e.m = 6'(m);
        e.s = 6'(s);
        e.r = r;
        e.d = d;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_out();
        snap_t exp_v;
        snap_t obs;
        string tag;
        exp_v = sb_q.pop_front();
        tag   = tag_q.pop_front();
        obs   = {bus.hrs, bus.min, bus.sec, bus.running, bus.done};
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed h=%0d m=%0d s=%0d run=%b done=%b expected h=%0d m=%0d s=%0d run=%b done=%b",
                   tag, obs.h, obs.m, obs.s, obs.r, obs.d,
                   exp_v.h, exp_v.m, exp_v.s, exp_v.r, exp_v.d);
        end
    endtask

    task automatic step_chk(input string tag, input bit tk, input bit ld,
                            input bit st, input bit ps, input int lh,
                            input int lm, input int ls, input int eh,
                            input int em, input int es, input bit er,
                            input bit ed);
        cyc(tk, ld, st, ps, lh, lm, ls);
        expect_out(tag, eh, em, es, er, ed);
        check_out();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.tick = 1'b0; bus.load = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
        bus.load_hrs = '0; bus.load_min = '0; bus.load_sec = '0;
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 0, 0, 0, 0, 0);
        check_out();
        rst = 1'b0;

        // 0:01:00 counted down to expiry
        step_chk("ld_0100",  0, 1, 0, 0, 0, 1, 0,  0, 1, 0,  0, 0);
        step_chk("start1",   0, 0, 1, 0, 0, 0, 0,  0, 1, 0,  1, 0);
        step_chk("tick1",    1, 0, 0, 0, 0, 0, 0,  0, 0, 59, 1, 0);
        for (int i = 0; i < 58; i++)
            step_chk("tick_run", 1, 0, 0, 0, 0, 0, 0, 0, 0, 58 - i, 1, 0);
        step_chk("expire",   1, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 1);
        step_chk("done_end", 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0);
        step_chk("no_wrap",  1, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0);

        // hour borrow, pause/resume
        step_chk("ld_1h",    0, 1, 0, 0, 1, 0, 0,  1, 0, 0,  0, 0);
        step_chk("start2",   0, 0, 1, 0, 0, 0, 0,  1, 0, 0,  1, 0);
        step_chk("borrow_h", 1, 0, 0, 0, 0, 0, 0,  0, 59, 59, 1, 0);
        step_chk("pause",    0, 0, 0, 1, 0, 0, 0,  0, 59, 59, 0, 0);
        for (int i = 0; i < 5; i++)
            step_chk("hold_tick", 1, 0, 0, 0, 0, 0, 0, 0, 59, 59, 0, 0);
        step_chk("pause_hold", 0, 0, 0, 1, 0, 0, 0, 0, 59, 59, 0, 0);
        step_chk("resume",   0, 0, 1, 0, 0, 0, 0,  0, 59, 59, 1, 0);
        step_chk("tick_res", 1, 0, 0, 0, 0, 0, 0,  0, 59, 58, 1, 0);
        step_chk("tick_pause", 1, 0, 0, 1, 0, 0, 0, 0, 59, 58, 0, 0);
        step_chk("resume2",  0, 0, 1, 0, 0, 0, 0,  0, 59, 58, 1, 0);
        step_chk("st_and_ps", 0, 0, 1, 1, 0, 0, 0, 0, 59, 58, 0, 0);

        // zero start ignored, preset saturation
        step_chk("ld_zero",  0, 1, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0);
        step_chk("st_zero",  0, 0, 1, 0, 0, 0, 0,  0, 0, 0,  0, 0);
        step_chk("st_zero2", 1, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0);
        step_chk("sat_sec",  0, 1, 0, 0, 0, 0, 63, 0, 0, 59, 0, 0);
        step_chk("sat_all",  0, 1, 0, 0, 31, 60, 63, 23, 59, 59, 0, 0);

        // load beats tick in RUN
        step_chk("ld_5",     0, 1, 0, 0, 0, 0, 5,  0, 0, 5,  0, 0);
        step_chk("start5",   0, 0, 1, 0, 0, 0, 0,  0, 0, 5,  1, 0);
        step_chk("ld_tick",  1, 1, 0, 0, 0, 0, 2,  0, 0, 2,  0, 0);
        step_chk("idle_tick", 1, 0, 0, 0, 0, 0, 0, 0, 0, 2,  0, 0);

        // asynchronous reset mid-run
        step_chk("ld_21030", 0, 1, 0, 0, 2, 10, 30, 2, 10, 30, 0, 0);
        step_chk("start6",   0, 0, 1, 0, 0, 0, 0,  2, 10, 30, 1, 0);
        step_chk("tick6",    1, 0, 0, 0, 0, 0, 0,  2, 10, 29, 1, 0);
        rst = 1'b1;
        #2;
        expect_out("async_rst", 0, 0, 0, 0, 0);
        check_out();
        #2;
        rst = 1'b0;
        step_chk("post_rst_st", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step_chk("post_rst_tk", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // expiry behaviour of the configured build
        step_chk("ld_2",     0, 1, 0, 0, 0, 0, 2,  0, 0, 2,  0, 0);
        step_chk("start7",   0, 0, 1, 0, 0, 0, 0,  0, 0, 2,  1, 0);
        step_chk("tick7a",   1, 0, 0, 0, 0, 0, 0,  0, 0, 1,  1, 0);
`ifdef HMS_CDT_AUTO_RELOAD_EN
        step_chk("reload",   1, 0, 0, 0, 0, 0, 0,  0, 0, 2,  1, 1);
        step_chk("reload_end", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0);
        step_chk("reload_tk", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0);
`else
        step_chk("expire2",  1, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 1);
        step_chk("expire2_end", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step_chk("idle_tk2", 1, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
